// File: rtl/disp_pkg.sv
// Shared digit codes, active-low seven-segment patterns and conversion FSM
// states for the display blocks.
package disp_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_DASH  = 4'hB;

  // Segment order {CA,CB,CC,CD,CE,CF,CG}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } disp_state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment pattern decoder,
// shared with the other display blocks.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      DIG_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_bcd_mux.sv
// Binary result to BCD (fixed-latency double dabble) driving a multiplexed
// common-anode seven-segment array. Define DISP_LZB_EN for leading-zero blanking.
module disp_bcd_mux
  import disp_pkg::*;
#(
  parameter int IN_W        = 19,
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [IN_W-1:0]     value,
  input  logic                clear,
  output logic                ready,
  output logic                busy,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int BIT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  disp_state_t       state, state_nxt;
  logic [IN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]  bcd, bcd_adj, commit_digits;
  logic [BIT_W-1:0]  bit_cnt;
  logic              ovf_flag;
  logic [BCD_W-1:0]  digits;
  logic [CNT_W-1:0]  refresh_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [3:0]        digit_sel;
  logic [6:0]        seg_next;

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state_nxt = SHIFT;
        SHIFT:   if (bit_cnt == '0) state_nxt = COMMIT;
        COMMIT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < N_DIGITS; i++)
      bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
  end

`ifdef DISP_LZB_EN
  logic seen_nz;
  // Blank zeros above the most significant non-zero digit; digit 0 always shows.
  always_comb begin
    commit_digits = bcd;
    seen_nz       = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) commit_digits[4*i +: 4] = DIG_BLANK;
    end
  end
`else
  assign commit_digits = bcd;
`endif

  // A 1 leaving the top nibble means the value needs more digits than we have.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_flag <= 1'b0;
      digits   <= {N_DIGITS{DIG_BLANK}};
      ovf      <= 1'b0;
    end else if (clear) begin
      digits   <= {N_DIGITS{DIG_BLANK}};
      ovf      <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr   <= value;
            bcd      <= '0;
            ovf_flag <= 1'b0;
            bit_cnt  <= BIT_W'(IN_W - 1);
          end
        end
        SHIFT: begin
          bcd      <= {bcd_adj[BCD_W-2:0], bin_sr[IN_W-1]};
          bin_sr   <= bin_sr << 1;
          ovf_flag <= ovf_flag | bcd_adj[BCD_W-1];
          bit_cnt  <= bit_cnt - BIT_W'(1);
        end
        COMMIT: begin
          if (ovf_flag) begin
            digits <= {N_DIGITS{DIG_DASH}};
            ovf    <= 1'b1;
          end else begin
            digits <= commit_digits;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign digit_sel = digits[4*digit_idx +: 4];

  seg7_decode u_decode (
    .code (digit_sel),
    .seg  (seg_next)
  );

  // Scan runs independently of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an          <= '1;
      seg         <= '1;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      an  <= ~(N_DIGITS'(1) << digit_idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_disp_bcd_mux.sv
// Directed bench for disp_bcd_mux: an 8-digit/19-bit instance and a 4-digit
// instance for overflow, checking latency, scanned segments, clear and reset.
module tb_disp_bcd_mux;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        load_a = 1'b0, clear_a = 1'b0;
  logic [18:0] value_a = '0;
  logic        ready_a, busy_a, ovf_a;
  logic [6:0]  seg_a;
  logic [7:0]  an_a;

  logic        load_b = 1'b0, clear_b = 1'b0;
  logic [13:0] value_b = '0;
  logic        ready_b, busy_b, ovf_b;
  logic [6:0]  seg_b;
  logic [3:0]  an_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  disp_bcd_mux #(.IN_W(19), .N_DIGITS(8), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load_a), .value(value_a), .clear(clear_a),
    .ready(ready_a), .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a)
  );

  disp_bcd_mux #(.IN_W(14), .N_DIGITS(4), .REFRESH_DIV(RD)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load_b), .value(value_b), .clear(clear_b),
    .ready(ready_b), .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
  );

  function automatic logic [6:0] expSeg(input logic [3:0] code);
    case (code)
      4'h0: return 7'h01;
      4'h1: return 7'h4F;
      4'h2: return 7'h12;
      4'h3: return 7'h06;
      4'h4: return 7'h4C;
      4'h5: return 7'h24;
      4'h6: return 7'h20;
      4'h7: return 7'h0F;
      4'h8: return 7'h00;
      4'h9: return 7'h04;
      4'hB: return 7'h7E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel, input int v);
    @(negedge clk);
    if (sel) begin load_b = 1'b1; value_b = 14'(v); end
    else     begin load_a = 1'b1; value_a = 19'(v); end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic convertAndCheck(input bit sel, input int v, input string tag);
    int n;
    applyStimulus(sel, v);
    n = 0;
    while ((sel ? busy_b : busy_a) && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, n, sel ? 14 : 19);
    checkOutput({tag, " ready in commit"}, sel ? ready_b : ready_a, 0);
    @(negedge clk);
    checkOutput({tag, " ready after commit"}, sel ? ready_b : ready_a, 1);
  endtask

  task automatic scanDigits(input bit sel, input logic [31:0] codes, input string tag);
    int nd, n;
    logic [7:0] target, cur_an;
    logic [6:0] cur_seg;
    nd = sel ? 4 : 8;
    @(negedge clk);
    for (int k = 0; k < nd; k++) begin
      target = ~(8'd1 << k);
      n = 0;
      cur_an = sel ? {4'hF, an_b} : an_a;
      while (cur_an != target && n < nd * RD + 4) begin
        @(negedge clk);
        n++;
        cur_an = sel ? {4'hF, an_b} : an_a;
      end
      checkOutput($sformatf("%s an slot %0d seen", tag, k), cur_an, target);
      cur_seg = sel ? seg_b : seg_a;
      checkOutput($sformatf("%s seg digit %0d", tag, k), cur_seg, expSeg(codes[4*k +: 4]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp_123456, exp_zero, exp_42;
`ifdef DISP_LZB_EN
    exp_123456 = 32'hAA123456;
    exp_zero   = 32'hAAAAAAA0;
    exp_42     = 32'hAAAAAA42;
`else
    exp_123456 = 32'h00123456;
    exp_zero   = 32'h00000000;
    exp_42     = 32'h00000042;
`endif

    #12;
    checkOutput("reset ready", ready_a, 1);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset ovf", ovf_a, 0);
    checkOutput("reset an", an_a, 8'hFF);
    checkOutput("reset seg", seg_a, 7'h7F);
    #10 rst_n = 1'b1;
    scanDigits(0, 32'hAAAAAAAA, "blank8");
    scanDigits(1, 32'h0000AAAA, "blank4");

    convertAndCheck(0, 123456, "v123456");
    checkOutput("v123456 ovf", ovf_a, 0);
    scanDigits(0, exp_123456, "v123456");

    convertAndCheck(0, 0, "v0");
    scanDigits(0, exp_zero, "v0");

    convertAndCheck(1, 10000, "v10000");
    checkOutput("v10000 ovf", ovf_b, 1);
    scanDigits(1, 32'h0000BBBB, "v10000");

    convertAndCheck(1, 9999, "v9999");
    checkOutput("v9999 ovf", ovf_b, 0);
    scanDigits(1, 32'h00009999, "v9999");

    // Blank the display, then load 500, retry 777 while busy, clear mid-shift.
    @(negedge clk) clear_a = 1'b1;
    @(negedge clk) clear_a = 1'b0;
    applyStimulus(0, 500);
    repeat (2) @(negedge clk);
    load_a = 1'b1; value_a = 19'd777;
    @(negedge clk) load_a = 1'b0;
    checkOutput("clr busy at t+3", busy_a, 1);
    repeat (7) @(negedge clk);
    checkOutput("clr busy at t+10", busy_a, 1);
    clear_a = 1'b1;
    @(negedge clk) clear_a = 1'b0;
    checkOutput("clr busy at t+11", busy_a, 0);
    checkOutput("clr ready at t+11", ready_a, 1);
    repeat (25) @(negedge clk);
    checkOutput("clr no restart busy", busy_a, 0);
    checkOutput("clr ovf", ovf_a, 0);
    scanDigits(0, 32'hAAAAAAAA, "clr");

    // Async reset mid-shift, with dut4 holding an overflow.
    applyStimulus(1, 12345);
    repeat (16) @(negedge clk);
    checkOutput("pre-reset ovf4", ovf_b, 1);
    applyStimulus(0, 300000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async ready", ready_a, 1);
    checkOutput("async busy", busy_a, 0);
    checkOutput("async an", an_a, 8'hFF);
    checkOutput("async seg", seg_a, 7'h7F);
    checkOutput("async ovf4", ovf_b, 0);
    checkOutput("async an4", an_b, 4'hF);
    #10 rst_n = 1'b1;
    convertAndCheck(0, 42, "v42");
    scanDigits(0, exp_42, "v42");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
